// File: rtl/ccm_arbiter.sv
// Two-master round-robin arbiter in front of the single-port CCM (1-cycle registered read).
// The owner output is the FSM state view: 0 = IDLE, 1 = OWN0, 2 = OWN1.
module ccm_arbiter #(
  parameter int          MAX_HOLD  = 8,
  parameter logic [31:0] CCM_BASE  = 32'h0000_8000,
  parameter int          CCM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [3:0]  m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [3:0]  m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_ready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [12:0] ccm_addr,
  output logic [3:0]  ccm_we,
  output logic [31:0] ccm_wdata,
  input  logic [31:0] ccm_rdata,
  output logic [1:0]  owner
);

  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;

  localparam logic [32:0] CCM_END  = {1'b0, CCM_BASE} + 33'(4 * CCM_WORDS);
  localparam logic [8:0]  HOLD_LIM = 9'(MAX_HOLD);

  state_t      state, state_nxt, other_state;
  logic        last_served, last_served_nxt;  // 0 = m0, 1 = m1
  logic [7:0]  hold_cnt, hold_cnt_nxt, hold_inc;
  logic        acc0, acc1, acc, own_req, oth_req, sel_win;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_we;
  logic        rsp_valid, rsp_err, rsp_mst;

  function automatic logic in_window(input logic [31:0] a);
    return ({1'b0, a} >= {1'b0, CCM_BASE}) && ({1'b0, a} < CCM_END);
  endfunction

  // Handshake: a master holds req (and its addr/we/wdata) until it sees ready
  // in the same cycle; req && ready is the accept, and only the owner ever gets ready.
  always_comb begin
    acc0      = (state == OWN0) && m0_req;
    acc1      = (state == OWN1) && m1_req;
    acc       = acc0 || acc1;
    sel_addr  = '0;
    sel_we    = '0;
    sel_wdata = '0;
    own_req   = 1'b0;
    oth_req   = 1'b0;
    case (state)
      OWN0: begin
        sel_addr  = m0_addr;
        sel_we    = m0_we;
        sel_wdata = m0_wdata;
        own_req   = m0_req;
        oth_req   = m1_req;
      end
      OWN1: begin
        sel_addr  = m1_addr;
        sel_we    = m1_we;
        sel_wdata = m1_wdata;
        own_req   = m1_req;
        oth_req   = m0_req;
      end
      default: ;
    endcase
    sel_win = in_window(sel_addr);
  end

  assign m0_ready  = acc0;
  assign m1_ready  = acc1;
  assign ccm_addr  = sel_addr[14:2];
  assign ccm_wdata = sel_wdata;
  assign ccm_we    = sel_we & {4{acc && sel_win}};
  assign owner     = 2'(state);

  // hold_cnt only counts accesses that made the other master wait.
  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    hold_cnt_nxt    = hold_cnt;
    other_state     = (state == OWN0) ? OWN1 : OWN0;
    hold_inc        = (acc && oth_req && hold_cnt != 8'hFF) ? hold_cnt + 8'd1 : hold_cnt;
    if (acc) last_served_nxt = acc1;
    case (state)
      IDLE: begin
        hold_cnt_nxt = '0;
        if (m0_req && m1_req) state_nxt = last_served ? OWN0 : OWN1;
        else if (m0_req)      state_nxt = OWN0;
        else if (m1_req)      state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        if (!own_req) begin
          state_nxt    = oth_req ? other_state : IDLE;
          hold_cnt_nxt = '0;
        end else if (oth_req && ({1'b0, hold_cnt} + {8'd0, acc} >= HOLD_LIM)) begin
          state_nxt    = other_state;
          hold_cnt_nxt = '0;
        end else begin
          hold_cnt_nxt = hold_inc;
        end
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      last_served <= 1'b1;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      hold_cnt    <= hold_cnt_nxt;
    end
  end

  // Responses carry the accepting master so they survive an ownership switch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_mst   <= 1'b0;
    end else begin
      rsp_valid <= acc && (sel_we == 4'd0);
      rsp_err   <= acc && !sel_win;
      rsp_mst   <= acc1;
    end
  end

  assign m0_rvalid = rsp_valid && !rsp_mst;
  assign m1_rvalid = rsp_valid && rsp_mst;
  assign m0_err    = rsp_err && !rsp_mst;
  assign m1_err    = rsp_err && rsp_mst;
  assign m0_rdata  = (m0_rvalid && !rsp_err) ? ccm_rdata : '0;
  assign m1_rdata  = (m1_rvalid && !rsp_err) ? ccm_rdata : '0;

endmodule

// File: tb/tb_ccm_arbiter.sv
// Bench for ccm_arbiter: CCM memory model, rule-level predictor checked every cycle,
// and directed scenarios with hand-computed expectations.
module tb_ccm_arbiter;

  localparam int MAX_HOLD = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        m0_req = 1'b0, m1_req = 1'b0;
  logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
  logic [3:0]  m0_we = '0, m1_we = '0;
  logic        m0_ready, m0_rvalid, m0_err, m1_ready, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata, ccm_wdata;
  logic [31:0] ccm_rdata = '0;
  logic [12:0] ccm_addr;
  logic [3:0]  ccm_we;
  logic [1:0]  owner;

  int n_vec = 0;
  int n_fail = 0;

  logic [31:0] ccm_mem [8192];
  logic [31:0] ref_mem [8192];
  logic [34:0] exp_q[$];  // {master, rvalid, err, rdata} due in the next cycle

  ccm_arbiter #(.MAX_HOLD(MAX_HOLD), .CCM_BASE(32'h0000_8000), .CCM_WORDS(8192)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .ccm_addr(ccm_addr), .ccm_we(ccm_we), .ccm_wdata(ccm_wdata), .ccm_rdata(ccm_rdata),
    .owner(owner)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // CCM: one-cycle registered read, byte-enabled write
  always @(posedge clk) begin
    ccm_rdata <= ccm_mem[ccm_addr];
    for (int b = 0; b < 4; b++)
      if (ccm_we[b]) ccm_mem[ccm_addr][8*b +: 8] <= ccm_wdata[8*b +: 8];
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic win(input logic [31:0] a);
    return (a >= 32'h0000_8000) && (a < 32'h0001_0000);
  endfunction

  // Predictor: owner 0/1/2, last master served, accesses granted while the other waited.
  int m_owner, m_last, m_streak;

  always @(negedge clk) begin : compare
    logic [34:0] e;
    logic [31:0] a, d, rd;
    logic [3:0]  w;
    logic        own_r, oth_r, inw;
    int          acc, n, idx;
    if (!rstn) begin
      m_owner = 0; m_last = 1; m_streak = 0;
      exp_q.delete();
      exp_q.push_back('0);
    end else begin
      e = exp_q.pop_front();
      check("m0_rvalid", m0_rvalid, !e[34] && e[33]);
      check("m1_rvalid", m1_rvalid, e[34] && e[33]);
      check("m0_err", m0_err, !e[34] && e[32]);
      check("m1_err", m1_err, e[34] && e[32]);
      if (!e[34] && e[33]) check("m0_rdata", m0_rdata, e[31:0]);
      if (e[34] && e[33])  check("m1_rdata", m1_rdata, e[31:0]);
      check("owner", owner, m_owner);
      acc = -1;
      if (m_owner == 1 && m0_req) acc = 0;
      if (m_owner == 2 && m1_req) acc = 1;
      check("m0_ready", m0_ready, acc == 0);
      check("m1_ready", m1_ready, acc == 1);
      if (acc >= 0) begin
        a = (acc == 0) ? m0_addr : m1_addr;
        w = (acc == 0) ? m0_we : m1_we;
        d = (acc == 0) ? m0_wdata : m1_wdata;
        inw = win(a);
        idx = int'((a - 32'h0000_8000) >> 2);
        check("ccm_we", ccm_we, inw ? w : 4'd0);
        if (inw) check("ccm_addr", ccm_addr, idx);
        if (inw && w != 4'd0) check("ccm_wdata", ccm_wdata, d);
        rd = (inw && w == 4'd0) ? ref_mem[idx] : 32'd0;
        if (inw)
          for (int b = 0; b < 4; b++)
            if (w[b]) ref_mem[idx][8*b +: 8] = d[8*b +: 8];
        exp_q.push_back({acc == 1, w == 4'd0, !inw, rd});
      end else begin
        check("ccm_we_idle", ccm_we, 4'd0);
        exp_q.push_back('0);
      end
      if (m_owner == 0) begin
        if (m0_req && m1_req) m_owner = (m_last == 1) ? 1 : 2;
        else if (m0_req)      m_owner = 1;
        else if (m1_req)      m_owner = 2;
        m_streak = 0;
      end else begin
        n = m_owner - 1;
        own_r = (n == 0) ? m0_req : m1_req;
        oth_r = (n == 0) ? m1_req : m0_req;
        if (acc >= 0) begin
          m_last = n;
          if (oth_r) m_streak++;
        end
        if (!own_r) begin
          m_owner = oth_r ? 2 - n : 0;
          m_streak = 0;
        end else if (oth_r && m_streak >= MAX_HOLD) begin
          m_owner = 2 - n;
          m_streak = 0;
        end
      end
    end
  end

  // driver tasks
  task automatic drive(input int m, input logic r, input logic [31:0] a,
                       input logic [3:0] w, input logic [31:0] d);
    if (m == 0) begin m0_req = r; m0_addr = a; m0_we = w; m0_wdata = d; end
    else        begin m1_req = r; m1_addr = a; m1_we = w; m1_wdata = d; end
  endtask

  // One access; returns just after the accepting edge with req dropped.
  task automatic access(input int m, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d, output logic [3:0] a_we, output logic [12:0] a_addr);
    int budget;
    logic rdy;
    @(posedge clk); #1;
    drive(m, 1'b1, a, w, d);
    budget = 20;
    do begin
      @(negedge clk);
      budget--;
      rdy = (m == 0) ? m0_ready : m1_ready;
    end while (!rdy && budget > 0);
    check("grant", rdy, 1'b1);
    a_we = ccm_we;
    a_addr = ccm_addr;
    @(posedge clk); #1;
    drive(m, 1'b0, a, 4'd0, 32'd0);
  endtask

  // directed scenarios
  initial begin : stim
    logic [3:0]  a_we;
    logic [12:0] a_addr;
    int          exp_m, budget;
    for (int i = 0; i < 8192; i++) begin
      ccm_mem[i] = {16'hA5A5, 16'(i)};
      ref_mem[i] = {16'hA5A5, 16'(i)};
    end
    ccm_mem[1] = 32'hDEAD_BEEF;
    ref_mem[1] = 32'hDEAD_BEEF;

    repeat (2) @(posedge clk);
    #1;
    check("rst_owner", owner, 2'd0);
    check("rst_ready", {m0_ready, m1_ready}, 2'b00);
    check("rst_ccm_we", ccm_we, 4'd0);
    check("rst_ccm_addr", ccm_addr, 13'd0);
    rstn = 1'b1;

    // m0 read of word 1: ready one cycle after req, data next cycle
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h0000_8004, 4'd0, 32'd0);
    @(negedge clk);
    check("t1_no_ready_idle", m0_ready, 1'b0);
    @(negedge clk);
    check("t1_ready", m0_ready, 1'b1);
    check("t1_owner", owner, 2'd1);
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 4'd0, 32'd0);
    @(negedge clk);
    check("t1_rvalid", m0_rvalid, 1'b1);
    check("t1_rdata", m0_rdata, 32'hDEAD_BEEF);

    // m1 halfword write then readback
    access(1, 32'h0000_A000, 4'b0011, 32'h1234_5678, a_we, a_addr);
    check("t2_ccm_we", a_we, 4'b0011);
    check("t2_ccm_addr", a_addr, 13'h800);
    @(negedge clk);
    check("t2_wr_rvalid", m1_rvalid, 1'b0);
    access(1, 32'h0000_A000, 4'd0, 32'd0, a_we, a_addr);
    check("t2_rd_ccm_we", a_we, 4'd0);
    @(negedge clk);
    check("t2_rdata", m1_rdata, 32'hA5A5_5678);

    // both request continuously from IDLE: 8/8 alternation, no dead cycle
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h0000_8004, 4'd0, 32'd0);
    drive(1, 1'b1, 32'h0000_A000, 4'd0, 32'd0);
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      exp_m = (i == 0) ? -1 : ((i - 1) / 8) % 2;
      check("rr_m0_ready", m0_ready, exp_m == 0);
      check("rr_m1_ready", m1_ready, exp_m == 1);
      if (i == 9) begin
        check("sw_m0_rvalid", m0_rvalid, 1'b1);
        check("sw_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        check("sw_m1_rvalid", m1_rvalid, 1'b0);
      end
    end
    @(posedge clk); #1;
    drive(0, 1'b0, 32'h0, 4'd0, 32'd0);
    drive(1, 1'b0, 32'h0, 4'd0, 32'd0);

    // window boundaries
    access(0, 32'h0002_0004, 4'd0, 32'd0, a_we, a_addr);
    check("oow_ccm_we", a_we, 4'd0);
    @(negedge clk);
    check("oow_rvalid", m0_rvalid, 1'b1);
    check("oow_rdata", m0_rdata, 32'd0);
    check("oow_err", m0_err, 1'b1);
    access(1, 32'h0001_0000, 4'b1111, 32'hCAFE_F00D, a_we, a_addr);
    check("oow_wr_ccm_we", a_we, 4'd0);
    @(negedge clk);
    check("oow_wr_err", m1_err, 1'b1);
    check("oow_wr_rvalid", m1_rvalid, 1'b0);
    access(1, 32'h0000_FFFC, 4'd0, 32'd0, a_we, a_addr);
    check("top_word_addr", a_addr, 13'h1FFF);
    @(negedge clk);
    check("top_word_err", m1_err, 1'b0);
    check("top_word_rdata", m1_rdata, 32'hA5A5_1FFF);
    access(0, 32'h0000_7FFC, 4'd0, 32'd0, a_we, a_addr);
    @(negedge clk);
    check("below_base_err", m0_err, 1'b1);

    // async reset with a read response pending
    @(posedge clk); #1;
    drive(0, 1'b1, 32'h0000_8004, 4'd0, 32'd0);
    budget = 20;
    do begin @(negedge clk); budget--; end while (!m0_ready && budget > 0);
    check("rst_grant", m0_ready, 1'b1);
    @(posedge clk); #1;
    check("rst_pending_rvalid", m0_rvalid, 1'b1);
    #1 rstn = 1'b0;
    #1;
    check("arst_outputs", {m0_ready, m0_rvalid, m0_err, m1_ready, m1_rvalid, m1_err, owner, ccm_we},
          12'd0);
    check("arst_rdata", m0_rdata, 32'd0);
    check("arst_ccm_addr", ccm_addr, 13'd0);
    drive(0, 1'b0, 32'h0, 4'd0, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
      check("post_rst_owner", owner, 2'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
